// File: rtl/tpu_top_ctrl_pkg.sv
// Shared defaults, FSM state encoding and host buffer-select codes for the
// TPU top-level controller and its global buffers.
package tpu_top_ctrl_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int ARRAY_SIZE_DEF  = 4;
    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int WORD_W_DEF      = ARRAY_SIZE_DEF * DATA_WIDTH_DEF;
    localparam int DIM_WIDTH_DEF   = 4;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int CNT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_RUN    = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_OUT  = 2'b10,
        SEL_NONE = 2'b11
    } host_sel_e;

endpackage

// File: rtl/tpu_gbuf.sv
// Single-port global buffer: synchronous write, registered read returning the
// old word on a same-index read-during-write. Contents clear on reset.
module tpu_gbuf
    import tpu_top_ctrl_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    always_comb begin
        rdata_d = mem_q[index];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the array is cleared on reset because software relies on
            // zeroed buffers; this costs a reset mux per bit, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking writes make the same-edge read see the old word.
            if (wr_en) begin
                mem_q[index] <= wdata;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tpu_top_ctrl.sv
// TPU top-level controller: job FSM with dimension check and watchdog, RUN
// cycle counter, and host/core arbitration over the A, B and OUT buffers.
module tpu_top_ctrl
    import tpu_top_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ARRAY_SIZE  = ARRAY_SIZE_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DIM_WIDTH   = DIM_WIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    localparam int WORD_W     = ARRAY_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  m,
    input  logic [DIM_WIDTH-1:0]  n,
    input  logic [DIM_WIDTH-1:0]  k,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    input  logic [1:0]            host_sel,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_index,
    input  logic [WORD_W-1:0]     host_wdata,
    output logic [WORD_W-1:0]     host_rdata,
    output logic                  host_stall,
    output logic                  core_start,
    output logic                  core_abort,
    output logic [DIM_WIDTH-1:0]  core_m,
    output logic [DIM_WIDTH-1:0]  core_n,
    output logic [DIM_WIDTH-1:0]  core_k,
    input  logic                  core_done,
    input  logic                  core_wr_en_a,
    input  logic                  core_wr_en_b,
    input  logic                  core_wr_en_o,
    input  logic [ADDR_WIDTH-1:0] core_index_a,
    input  logic [ADDR_WIDTH-1:0] core_index_b,
    input  logic [ADDR_WIDTH-1:0] core_index_o,
    input  logic [WORD_W-1:0]     core_wdata_a,
    input  logic [WORD_W-1:0]     core_wdata_b,
    input  logic [WORD_W-1:0]     core_wdata_o,
    output logic [WORD_W-1:0]     core_rdata_a,
    output logic [WORD_W-1:0]     core_rdata_b,
    output logic [WORD_W-1:0]     core_rdata_o
);

    // Watchdog counter only has to reach TIMEOUT_CYC-1.
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e                state_q, state_d;
    logic                  err_q, err_d;
    logic [DIM_WIDTH-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]       run_q, run_d;
    host_sel_e             hsel_q, hsel_d;
    logic                  dims_ok;
    logic                  timeout_hit;

    logic                  we_a, we_b, we_o;
    logic [ADDR_WIDTH-1:0] idx_a, idx_b, idx_o;
    logic [WORD_W-1:0]     wd_a, wd_b, wd_o;
    logic [WORD_W-1:0]     rd_a, rd_b, rd_o;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = done && err_q;
    assign core_start  = (state_q == ST_LAUNCH);
    assign host_stall  = busy;
    assign cycle_count = cnt_q;
    assign core_m      = m_q;
    assign core_n      = n_q;
    assign core_k      = k_q;
    assign dims_ok     = (m != '0) && (n != '0) && (k != '0);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (run_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        err_d      = err_q;
        m_d        = m_q;
        n_d        = n_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        core_abort = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        m_d     = m;
                        n_d     = n;
                        k_d     = k;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_LAUNCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LAUNCH: begin
                run_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                run_d = run_q + TO_W'(1);
                // A completion in the limit cycle beats the watchdog.
                if (core_done) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    core_abort = 1'b1;
                    err_d      = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hsel_d = busy ? SEL_NONE : host_sel_e'(host_sel);
        we_a   = busy ? core_wr_en_a : (host_wr_en && (host_sel == SEL_A));
        we_b   = busy ? core_wr_en_b : (host_wr_en && (host_sel == SEL_B));
        we_o   = busy ? core_wr_en_o : (host_wr_en && (host_sel == SEL_OUT));
        idx_a  = busy ? core_index_a : host_index;
        idx_b  = busy ? core_index_b : host_index;
        idx_o  = busy ? core_index_o : host_index;
        wd_a   = busy ? core_wdata_a : host_wdata;
        wd_b   = busy ? core_wdata_b : host_wdata;
        wd_o   = busy ? core_wdata_o : host_wdata;
    end

    always_comb begin
        host_rdata = '0;
        if (!busy) begin
            unique case (hsel_q)
                SEL_A:   host_rdata = rd_a;
                SEL_B:   host_rdata = rd_b;
                SEL_OUT: host_rdata = rd_o;
                default: host_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            hsel_q  <= SEL_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            hsel_q  <= hsel_d;
        end
    end

    tpu_gbuf #(.WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) u_buf_a (
        .clk(clk), .rst(rst), .wr_en(we_a), .index(idx_a), .wdata(wd_a), .rdata(rd_a)
    );

    tpu_gbuf #(.WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) u_buf_b (
        .clk(clk), .rst(rst), .wr_en(we_b), .index(idx_b), .wdata(wd_b), .rdata(rd_b)
    );

    tpu_gbuf #(.WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) u_buf_o (
        .clk(clk), .rst(rst), .wr_en(we_o), .index(idx_o), .wdata(wd_o), .rdata(rd_o)
    );

    assign core_rdata_a = rd_a;
    assign core_rdata_b = rd_b;
    assign core_rdata_o = rd_o;

endmodule

// File: tb/tb_tpu_top_ctrl.sv
// Scoreboard bench for tpu_top_ctrl: a default instance for buffer/job tests
// and a second instance with a 16-cycle watchdog for the timeout tests.
module tb_tpu_top_ctrl;
    import tpu_top_ctrl_pkg::*;

    localparam int DW  = 8;
    localparam int AS  = 4;
    localparam int AW  = 8;
    localparam int DMW = 4;
    localparam int CW  = 16;
    localparam int WW  = AS * DW;

    typedef struct packed {
        logic          err;
        logic [CW-1:0] cnt;
    } done_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, w_start, core_done, w_core_done;
    logic [DMW-1:0] m, n, k;
    logic [1:0]     host_sel;
    logic           host_wr_en;
    logic [AW-1:0]  host_index;
    logic [WW-1:0]  host_wdata;
    logic           core_wr_en_a, core_wr_en_b, core_wr_en_o;
    logic [AW-1:0]  core_index_a, core_index_b, core_index_o;
    logic [WW-1:0]  core_wdata_a, core_wdata_b, core_wdata_o;

    logic           busy, done, error, host_stall, core_start, core_abort;
    logic [CW-1:0]  cycle_count;
    logic [WW-1:0]  host_rdata, core_rdata_a, core_rdata_b, core_rdata_o;
    logic [DMW-1:0] core_m, core_n, core_k;

    logic           w_busy, w_done, w_error, w_host_stall, w_core_start, w_core_abort;
    logic [CW-1:0]  w_cycle_count;
    logic [WW-1:0]  w_host_rdata, w_core_rdata_a, w_core_rdata_b, w_core_rdata_o;
    logic [DMW-1:0] w_core_m, w_core_n, w_core_k;

    tpu_top_ctrl #(
        .DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW),
        .TIMEOUT_CYC(4096), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .k(k),
        .busy(busy), .done(done), .error(error), .cycle_count(cycle_count),
        .host_sel(host_sel), .host_wr_en(host_wr_en), .host_index(host_index),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_stall(host_stall),
        .core_start(core_start), .core_abort(core_abort),
        .core_m(core_m), .core_n(core_n), .core_k(core_k), .core_done(core_done),
        .core_wr_en_a(core_wr_en_a), .core_wr_en_b(core_wr_en_b), .core_wr_en_o(core_wr_en_o),
        .core_index_a(core_index_a), .core_index_b(core_index_b), .core_index_o(core_index_o),
        .core_wdata_a(core_wdata_a), .core_wdata_b(core_wdata_b), .core_wdata_o(core_wdata_o),
        .core_rdata_a(core_rdata_a), .core_rdata_b(core_rdata_b), .core_rdata_o(core_rdata_o)
    );

    tpu_top_ctrl #(
        .DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW),
        .TIMEOUT_CYC(16), .CNT_WIDTH(CW)
    ) u_dut_wd (
        .clk(clk), .rst(rst), .start(w_start), .m(m), .n(n), .k(k),
        .busy(w_busy), .done(w_done), .error(w_error), .cycle_count(w_cycle_count),
        .host_sel(host_sel), .host_wr_en(host_wr_en), .host_index(host_index),
        .host_wdata(host_wdata), .host_rdata(w_host_rdata), .host_stall(w_host_stall),
        .core_start(w_core_start), .core_abort(w_core_abort),
        .core_m(w_core_m), .core_n(w_core_n), .core_k(w_core_k), .core_done(w_core_done),
        .core_wr_en_a(core_wr_en_a), .core_wr_en_b(core_wr_en_b), .core_wr_en_o(core_wr_en_o),
        .core_index_a(core_index_a), .core_index_b(core_index_b), .core_index_o(core_index_o),
        .core_wdata_a(core_wdata_a), .core_wdata_b(core_wdata_b), .core_wdata_o(core_wdata_o),
        .core_rdata_a(w_core_rdata_a), .core_rdata_b(w_core_rdata_b), .core_rdata_o(w_core_rdata_o)
    );

    int n_vec = 0;
    int n_miss = 0;

    done_exp_t     done_q[$];
    done_exp_t     w_done_q[$];
    logic [WW-1:0] rd_q[$];
    logic          rd_issue = 1'b0;
    logic          rd_vld = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] sel, input logic [AW-1:0] idx, input logic [WW-1:0] d);
        host_sel   = sel;
        host_index = idx;
        host_wdata = d;
        host_wr_en = 1'b1;
        step();
        host_wr_en = 1'b0;
        host_sel   = SEL_NONE;
    endtask

    task automatic host_read(input logic [1:0] sel, input logic [AW-1:0] idx, input logic [WW-1:0] exp);
        host_sel   = sel;
        host_index = idx;
        host_wr_en = 1'b0;
        rd_issue   = 1'b1;
        rd_q.push_back(exp);
        step();
        rd_issue   = 1'b0;
        host_sel   = SEL_NONE;
    endtask

    // Monitor: compares host reads one cycle after issue and every done pulse.
    initial begin
        done_exp_t     e;
        logic [WW-1:0] r;
        forever begin
            @(posedge clk);
            rd_vld = rd_issue;
            @(negedge clk);
            if (rd_vld) begin
                if (rd_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL rd_scoreboard: read with empty queue at %0t", $time);
                end else begin
                    r = rd_q.pop_front();
                    check("host_rdata", host_rdata, r);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL done_unexpected: got done=1 expected none at %0t", $time);
                end else begin
                    e = done_q.pop_front();
                    check("done_error", error, e.err);
                    check("done_cycle_count", cycle_count, e.cnt);
                end
            end
            if (w_done) begin
                if (w_done_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL wd_done_unexpected: got done=1 expected none at %0t", $time);
                end else begin
                    e = w_done_q.pop_front();
                    check("wd_done_error", w_error, e.err);
                    check("wd_done_cycle_count", w_cycle_count, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; w_start = 1'b0; core_done = 1'b0; w_core_done = 1'b0;
        m = '0; n = '0; k = '0;
        host_sel = SEL_NONE; host_wr_en = 1'b0; host_index = '0; host_wdata = '0;
        core_wr_en_a = 1'b0; core_wr_en_b = 1'b0; core_wr_en_o = 1'b0;
        core_index_a = '0; core_index_b = '0; core_index_o = '0;
        core_wdata_a = '0; core_wdata_b = '0; core_wdata_o = '0;
        repeat (3) step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_abort", core_abort, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_core_m", core_m, 0);
        rst = 1'b1;
        step();

        // T1 host load/readback
        host_write(SEL_A, 8'd3, 32'h11223344);
        host_read(SEL_A, 8'd3, 32'h11223344);
        host_read(SEL_B, 8'd3, 32'h0);

        // T2 normal job: core_done 20 cycles after core_start
        m = 4; n = 4; k = 4; start = 1'b1;
        step();
        start = 1'b0;
        check("t2_core_start", core_start, 1);
        check("t2_busy", busy, 1);
        check("t2_core_m", core_m, 4);
        done_q.push_back('{err: 1'b0, cnt: 16'd20});
        repeat (20) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check("t2_busy_in_done", busy, 1);
        step();
        check("t2_busy_fall", busy, 0);

        // T3 zero-dimension reject; cycle_count keeps the previous job's value
        m = 0; n = 4; k = 4; start = 1'b1;
        done_q.push_back('{err: 1'b1, cnt: 16'd20});
        step();
        start = 1'b0;
        check("t3_done", done, 1);
        check("t3_core_start", core_start, 0);
        step();
        check("t3_busy_after", busy, 0);
        check("t3_core_start_after", core_start, 0);

        // T4 watchdog at 16 RUN cycles, then core_done in the limit cycle
        m = 1; n = 1; k = 1; w_start = 1'b1;
        step();
        w_start = 1'b0;
        check("t4_core_start", w_core_start, 1);
        repeat (15) step();
        check("t4_abort_early", w_core_abort, 0);
        w_done_q.push_back('{err: 1'b1, cnt: 16'd16});
        step();
        check("t4_abort", w_core_abort, 1);
        step();
        check("t4_busy_in_done", w_busy, 1);
        step();
        check("t4_busy_after", w_busy, 0);

        w_start = 1'b1;
        step();
        w_start = 1'b0;
        repeat (15) step();
        w_done_q.push_back('{err: 1'b0, cnt: 16'd16});
        step();
        w_core_done = 1'b1;
        #1;
        check("t4_abort_suppressed", w_core_abort, 0);
        step();
        w_core_done = 1'b0;
        step();

        // T5 arbitration while busy
        host_write(SEL_B, 8'd0, 32'hCAFEF00D);
        m = 2; n = 3; k = 1; start = 1'b1;
        step();
        start = 1'b0;
        check("t5_core_m", core_m, 2);
        check("t5_core_n", core_n, 3);
        check("t5_core_k", core_k, 1);
        check("t5_host_stall", host_stall, 1);
        host_sel = SEL_B; host_index = 8'd0; host_wdata = 32'h0BADBEEF; host_wr_en = 1'b1;
        core_wr_en_o = 1'b1; core_index_o = 8'd5; core_wdata_o = 32'h0000DEAD;
        step();
        host_wr_en = 1'b0; host_sel = SEL_NONE; core_wr_en_o = 1'b0;
        check("t5_rdw_old", core_rdata_o, 32'h0);
        host_read(SEL_B, 8'd0, 32'h0);
        check("t5_core_rdata_o", core_rdata_o, 32'h0000DEAD);
        done_q.push_back('{err: 1'b0, cnt: 16'd2});
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        host_read(SEL_B, 8'd0, 32'hCAFEF00D);
        host_read(SEL_OUT, 8'd5, 32'h0000DEAD);

        // T6 reset during RUN
        host_write(SEL_A, 8'd7, 32'h00000055);
        m = 1; n = 1; k = 1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t6_busy_run", busy, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_cycle_count", cycle_count, 0);
        check("t6_core_m", core_m, 0);
        host_read(SEL_A, 8'd7, 32'h0);
        host_read(SEL_OUT, 8'd5, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_restart", core_start, 1);
        done_q.push_back('{err: 1'b0, cnt: 16'd1});
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        check("t6_busy_end", busy, 0);

        repeat (3) step();
        check("done_q_drained", done_q.size(), 0);
        check("wd_done_q_drained", w_done_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
